// File: rtl/serial_operand_feeder.sv
// Serialises a WIDTH-bit operand pair plus carry-in LSB-first for the bit-serial adder.
// Latency: bit 0 two cycles after accept (one CLEAR cycle first); backpressure: in_ready only in IDLE.
module serial_operand_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             a,
    output logic             b,
    output logic             cin,
    output logic             add_clr,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             c_reg;
    logic [CW-1:0]    count;
    logic             ready_en;
    logic             accept;

    assign accept = in_valid && in_ready;

    // ready_en keeps in_ready low until the first edge after reset is released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            c_reg    <= 1'b0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (accept) begin
                sh_a  <= op_a;
                sh_b  <= op_b;
                c_reg <= cin_in;
                count <= '0;
            end else if (state == SHIFT) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                if (count != LAST)
                    count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        cin       = 1'b0;
        add_clr   = 1'b0;
        bit_valid = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ready_en;
                if (in_valid && ready_en)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                add_clr   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                a         = sh_a[0];
                b         = sh_b[0];
                cin       = (count == '0) ? c_reg : 1'b0;
                last_bit  = (count == LAST);
                if (count == LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder at WIDTH 4, 6 and 1.
module tb_serial_operand_feeder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // WIDTH=4 instance
    logic       in_valid = 1'b0, in_ready;
    logic [3:0] op_a = '0, op_b = '0;
    logic       cin_in = 1'b0;
    logic       a, b, cin, add_clr, bit_valid, last_bit;

    serial_operand_feeder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin_in(cin_in), .a(a), .b(b), .cin(cin),
        .add_clr(add_clr), .bit_valid(bit_valid), .last_bit(last_bit)
    );

    // WIDTH=6 instance
    logic       in_valid6 = 1'b0, in_ready6;
    logic [5:0] op_a6 = '0, op_b6 = '0;
    logic       cin_in6 = 1'b0;
    logic       a6, b6, cin6, add_clr6, bit_valid6, last_bit6;

    serial_operand_feeder #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(in_ready6),
        .op_a(op_a6), .op_b(op_b6), .cin_in(cin_in6), .a(a6), .b(b6), .cin(cin6),
        .add_clr(add_clr6), .bit_valid(bit_valid6), .last_bit(last_bit6)
    );

    // WIDTH=1 instance
    logic       in_valid1 = 1'b0, in_ready1;
    logic [0:0] op_a1 = '0, op_b1 = '0;
    logic       cin_in1 = 1'b0;
    logic       a1, b1, cin1, add_clr1, bit_valid1, last_bit1;

    serial_operand_feeder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .cin_in(cin_in1), .a(a1), .b(b1), .cin(cin1),
        .add_clr(add_clr1), .bit_valid(bit_valid1), .last_bit(last_bit1)
    );

    typedef struct {
        logic [3:0] op_a;
        logic [3:0] op_b;
        logic       cin_in;
        logic [3:0] exp_a;   // bit i = expected serial bit i
        logic [3:0] exp_b;
        logic [3:0] exp_cin;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready4(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_ready_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run4(input vec_t v, input string tag);
        wait_ready4(tag);
        @(negedge clk);
        in_valid = 1'b1; op_a = v.op_a; op_b = v.op_b; cin_in = v.cin_in;
        @(posedge clk); #1;
        // inputs scrambled right after acceptance must not disturb the stream
        in_valid = 1'b0; op_a = ~v.op_a; op_b = ~v.op_b; cin_in = ~v.cin_in;
        chk({tag, "_clr"}, {31'd0, add_clr}, 32'd1);
        chk({tag, "_clr_bv"}, {31'd0, bit_valid}, 32'd0);
        chk({tag, "_clr_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_clr_a"}, {31'd0, a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_bv%0d", tag, i), {31'd0, bit_valid}, 32'd1);
            chk($sformatf("%s_a%0d", tag, i), {31'd0, a}, {31'd0, v.exp_a[i]});
            chk($sformatf("%s_b%0d", tag, i), {31'd0, b}, {31'd0, v.exp_b[i]});
            chk($sformatf("%s_cin%0d", tag, i), {31'd0, cin}, {31'd0, v.exp_cin[i]});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, last_bit}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rdy%0d", tag, i), {31'd0, in_ready}, 32'd0);
            in_valid = (i < 3) ? ~in_valid : 1'b0;
            op_a = op_a ^ 4'b0101;
        end
        @(posedge clk); #1;
        chk({tag, "_done_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_done_bv"}, {31'd0, bit_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_no_extra_clr"}, {31'd0, add_clr}, 32'd0);
    endtask

    initial begin
        int t1, t2, seen;
        logic [5:0] ea6, eb6;

        vecs[0] = '{4'b1010, 4'b1110, 1'b0, 4'b1010, 4'b1110, 4'b0000};
        vecs[1] = '{4'b0011, 4'b0001, 1'b1, 4'b0011, 4'b0001, 4'b0001};
        vecs[2] = '{4'b1111, 4'b0110, 1'b1, 4'b1111, 4'b0110, 4'b0001};
        vecs[3] = '{4'b0000, 4'b1001, 1'b0, 4'b0000, 4'b1001, 4'b0000};

        // reset held low for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {31'd0, a}, 32'd0);
        chk("rst_b", {31'd0, b}, 32'd0);
        chk("rst_cin", {31'd0, cin}, 32'd0);
        chk("rst_clr", {31'd0, add_clr}, 32'd0);
        chk("rst_bv", {31'd0, bit_valid}, 32'd0);
        chk("rst_last", {31'd0, last_bit}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < 4; v++)
            run4(vecs[v], $sformatf("vec%0d", v));

        // in_valid held high: two accepts spaced WIDTH+2 apart
        wait_ready4("b2b");
        @(negedge clk);
        in_valid = 1'b1; op_a = 4'b0101; op_b = 4'b0011; cin_in = 1'b0;
        t1 = -1; t2 = -1; seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (add_clr === 1'b1) begin
                if (seen == 0) t1 = c; else t2 = c;
                seen++;
                if (seen == 2) begin
                    in_valid = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_pulses", seen, 32'd2);
        chk("b2b_gap", t2 - t1, 32'd6);
        wait_ready4("b2b_drain");

        // WIDTH=6 stream
        @(negedge clk);
        in_valid6 = 1'b1; op_a6 = 6'b001011; op_b6 = 6'b101000; cin_in6 = 1'b0;
        @(posedge clk); #1;
        in_valid6 = 1'b0; op_a6 = 6'b111111;
        chk("w6_clr", {31'd0, add_clr6}, 32'd1);
        ea6 = 6'b001011;   // a = 1,1,0,1,0,0
        eb6 = 6'b101000;   // b = 0,0,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("w6_bv%0d", i), {31'd0, bit_valid6}, 32'd1);
            chk($sformatf("w6_a%0d", i), {31'd0, a6}, {31'd0, ea6[i]});
            chk($sformatf("w6_b%0d", i), {31'd0, b6}, {31'd0, eb6[i]});
            chk($sformatf("w6_last%0d", i), {31'd0, last_bit6}, (i == 5) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        chk("w6_done_rdy", {31'd0, in_ready6}, 32'd1);

        // WIDTH=1: CLEAR then one SHIFT cycle carrying cin
        @(negedge clk);
        in_valid1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b0; cin_in1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("w1_clr", {31'd0, add_clr1}, 32'd1);
        @(posedge clk); #1;
        chk("w1_bv", {31'd0, bit_valid1}, 32'd1);
        chk("w1_last", {31'd0, last_bit1}, 32'd1);
        chk("w1_a", {31'd0, a1}, 32'd1);
        chk("w1_b", {31'd0, b1}, 32'd0);
        chk("w1_cin", {31'd0, cin1}, 32'd1);
        @(posedge clk); #1;
        chk("w1_idle_bv", {31'd0, bit_valid1}, 32'd0);
        chk("w1_idle_rdy", {31'd0, in_ready1}, 32'd1);

        // reset asserted during SHIFT bit 1 clears outputs without a clock edge
        wait_ready4("mid");
        @(negedge clk);
        in_valid = 1'b1; op_a = 4'b1111; op_b = 4'b1111; cin_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_bv_before", {31'd0, bit_valid}, 32'd1);
        chk("mid_a_before", {31'd0, a}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_a", {31'd0, a}, 32'd0);
        chk("mid_b", {31'd0, b}, 32'd0);
        chk("mid_bv", {31'd0, bit_valid}, 32'd0);
        chk("mid_clr", {31'd0, add_clr}, 32'd0);
        chk("mid_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run4(vecs[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
